// File: rtl/tick_gen_multi.sv
// tick_gen_multi
//   Clock-enable generator for the stopwatch datapath. Every timing enable is
//   derived from clk by integer division; no divided clocks are produced.
//
//   Ports
//     clk          master clock
//     RESET        synchronous, active-high reset
//     ADJ          rate select for tick_out: 0 = normal, 1 = adjust
//     PAUSE_PULSE  single-cycle request; toggles the paused state
//     tick_out     one-cycle timer advance enable (NORM_HZ or ADJ_HZ)
//     scan_tick    one-cycle display scan enable (SCAN_HZ)
//     blink        blink phase level, full period at BLINK_HZ
//     paused       current paused state
//
//   All outputs come straight from registers; there is no combinational path
//   from any input to any output.
module tick_gen_multi #(
  parameter int CLK_HZ   = 100000000,
  parameter int NORM_HZ  = 1,
  parameter int ADJ_HZ   = 2,
  parameter int SCAN_HZ  = 500,
  parameter int BLINK_HZ = 4
) (
  input  logic clk,
  input  logic RESET,
  input  logic ADJ,
  input  logic PAUSE_PULSE,
  output logic tick_out,
  output logic scan_tick,
  output logic blink,
  output logic paused
);

  // ---------------------------------------------------------------------------
  // Derived divisors (integer truncation) and counter width
  // ---------------------------------------------------------------------------
  localparam int NORM_DIV   = CLK_HZ / NORM_HZ;
  localparam int ADJ_DIV    = CLK_HZ / ADJ_HZ;
  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);

  localparam int MAX_AB  = (NORM_DIV > ADJ_DIV) ? NORM_DIV : ADJ_DIV;
  localparam int MAX_CD  = (SCAN_DIV > BLINK_HALF) ? SCAN_DIV : BLINK_HALF;
  localparam int MAX_DIV = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_DIV);

  localparam logic [CW-1:0] NORM_LAST  = CW'(NORM_DIV - 1);
  localparam logic [CW-1:0] ADJ_LAST   = CW'(ADJ_DIV - 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  // A divisor below 2 cannot produce a one-cycle enable with a low phase.
  if (NORM_DIV < 2) begin : g_bad_norm
    $error("tick_gen_multi: NORM_DIV must be >= 2");
  end
  if (ADJ_DIV < 2) begin : g_bad_adj
    $error("tick_gen_multi: ADJ_DIV must be >= 2");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan
    $error("tick_gen_multi: SCAN_DIV must be >= 2");
  end
  if (BLINK_HALF < 2) begin : g_bad_blink
    $error("tick_gen_multi: BLINK_HALF must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Pause state machine
  // ---------------------------------------------------------------------------
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pstate_t;

  pstate_t pstate, pstate_nxt;

  always_ff @(posedge clk) begin
    if (RESET) pstate <= RUN;
    else       pstate <= pstate_nxt;
  end

  always_comb begin
    pstate_nxt = pstate;
    if (PAUSE_PULSE) begin
      pstate_nxt = (pstate == RUN) ? HOLD : RUN;
    end
  end

  always_comb begin
    paused = (pstate == HOLD);
  end

  // ---------------------------------------------------------------------------
  // Main timer divider
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] div_last;
  logic          adj_q, adj_nxt;
  logic          tick_nxt;

  always_comb begin
    div_last = adj_q ? ADJ_LAST : NORM_LAST;
    cnt_nxt  = cnt;
    adj_nxt  = adj_q;
    tick_nxt = 1'b0;
    // Mode change outranks pause so a rate switch always restarts the period.
    // 'paused' is the registered state, so a pulse in this cycle does not yet
    // gate counting and a coincident wrap still emits its tick.
    if (ADJ != adj_q) begin
      cnt_nxt = '0;
      adj_nxt = ADJ;
    end else if (paused) begin
      cnt_nxt = cnt;
    end else if (cnt == div_last) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
    end else begin
      cnt_nxt = cnt + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt      <= '0;
      adj_q    <= ADJ;
      tick_out <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      adj_q    <= adj_nxt;
      tick_out <= tick_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan divider (free-running)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] scnt;

  always_ff @(posedge clk) begin
    if (RESET) begin
      scnt      <= '0;
      scan_tick <= 1'b0;
    end else if (scnt == SCAN_LAST) begin
      scnt      <= '0;
      scan_tick <= 1'b1;
    end else begin
      scnt      <= scnt + ONE;
      scan_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink half-period divider (free-running)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] bcnt;

  always_ff @(posedge clk) begin
    if (RESET) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt  <= bcnt + ONE;
    end
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi
//   Directed bench for tick_gen_multi with CLK_HZ=40, NORM_HZ=1, ADJ_HZ=2,
//   SCAN_HZ=10, BLINK_HZ=4 (NORM_DIV=40, ADJ_DIV=20, SCAN_DIV=4, BLINK_HALF=5).
//   Expected output values for each cycle are queued when the inputs for that
//   cycle are driven and checked one time unit after the rising edge.
module tb_tick_gen_multi;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic ADJ = 1'b0;
  logic PAUSE_PULSE = 1'b0;
  logic tick_out, scan_tick, blink, paused;

  tick_gen_multi #(
    .CLK_HZ  (40),
    .NORM_HZ (1),
    .ADJ_HZ  (2),
    .SCAN_HZ (10),
    .BLINK_HZ(4)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .ADJ        (ADJ),
    .PAUSE_PULSE(PAUSE_PULSE),
    .tick_out   (tick_out),
    .scan_tick  (scan_tick),
    .blink      (blink),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic t;
    logic s;
    logic b;
    logic p;
  } exp_t;

  exp_t  sb[$];
  int    ticks[$];
  int    n = 0;
  logic  exp_p = 1'b0;
  int    total = 0;
  int    bad = 0;
  string scen = "init";

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s/%s cycle=%0d observed=%b expected=%b", scen, tag, cyc, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge outputs, check them.
  task automatic step(input logic pp, input logic adj, input logic rst);
    exp_t e, got;
    @(negedge clk);
    PAUSE_PULSE = pp;
    ADJ         = adj;
    RESET       = rst;
    if (rst) begin
      n     = 0;
      exp_p = 1'b0;
      e.cyc = 0;
      e.t   = 1'b0;
      e.s   = 1'b0;
      e.b   = 1'b0;
      e.p   = 1'b0;
    end else begin
      n     = n + 1;
      if (pp) exp_p = ~exp_p;
      e.cyc = n;
      e.t   = 1'b0;
      if (ticks.size() > 0 && ticks[0] == n) begin
        e.t = 1'b1;
        void'(ticks.pop_front());
      end
      e.s = (n % 4) == 0;
      e.b = ((n / 5) % 2) == 1;
      e.p = exp_p;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("tick_out",  got.cyc, tick_out,  got.t);
    chk("scan_tick", got.cyc, scan_tick, got.s);
    chk("blink",     got.cyc, blink,     got.b);
    chk("paused",    got.cyc, paused,    got.p);
  endtask

  task automatic run_to(input int last, input logic adj);
    while (n < last) step(1'b0, adj, 1'b0);
  endtask

  task automatic do_reset(input logic adj);
    step(1'b0, adj, 1'b1);
    step(1'b0, adj, 1'b1);
  endtask

  initial begin
    // 1: normal rate, scan and blink cadence
    scen = "normal";
    ticks = '{40, 80, 120};
    do_reset(1'b0);
    run_to(130, 1'b0);

    // 2: adjust rate from reset, then switch back to normal at cycle 70
    scen = "adj_switch";
    ticks = '{20, 40, 60, 110};
    do_reset(1'b1);
    run_to(69, 1'b1);
    run_to(115, 1'b0);

    // 3: pause at 25, resume at 60, partial period preserved
    scen = "pause";
    ticks = '{75, 115};
    do_reset(1'b0);
    run_to(24, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to(59, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to(120, 1'b0);

    // 4: pause pulse coincident with the wrap at 40, resume at 60
    scen = "pause_at_wrap";
    ticks = '{40, 100};
    do_reset(1'b0);
    run_to(39, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to(59, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to(101, 1'b0);

    // 5: paused at 10, reset mid-count at 30 for two cycles
    scen = "mid_reset";
    ticks = {};
    do_reset(1'b0);
    run_to(9, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to(29, 1'b0);
    do_reset(1'b0);
    ticks = '{40};
    run_to(45, 1'b0);

    // 6: mode change and pause in the same cycle (15), resume at 50
    scen = "adj_and_pause";
    ticks = '{70};
    do_reset(1'b0);
    run_to(14, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_to(49, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    run_to(75, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
